// File: rtl/ht_traffic_gen.sv
// ht_traffic_gen: command/result traffic engine for hash_table_top.
// Sequential, random-mix and insert/delete streams with bounded outstanding.
module ht_traffic_gen #(
  parameter int KEY_WIDTH       = 32,
  parameter int VALUE_WIDTH     = 16,
  parameter int CNT_WIDTH       = 16,
  parameter int KEY_SPACE_BITS  = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [CNT_WIDTH-1:0]   num_cmds_i,
  input  logic [KEY_WIDTH-1:0]   key_base_i,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic [KEY_WIDTH-1:0]   cmd_key_o,
  output logic [VALUE_WIDTH-1:0] cmd_value_o,
  output logic [1:0]             cmd_opcode_o,
  input  logic                   res_valid_i,
  output logic                   res_ready_o,
  input  logic                   res_ok_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [CNT_WIDTH:0]     sent_cnt_o,
  output logic [CNT_WIDTH:0]     recv_cnt_o,
  output logic [CNT_WIDTH:0]     ok_cnt_o,
  output logic [CNT_WIDTH:0]     stall_cnt_o
);

  localparam int CW = CNT_WIDTH + 1;
  localparam logic [1:0] OP_SEARCH = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_n;
  logic [1:0]           mode_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [KEY_WIDTH-1:0] base_q;
  logic [15:0]          lfsr, lfsr_n;
  logic [CW-1:0]        sent, recv, ok, stall;
  logic                 err, rdy;
  logic [CW-1:0]        total, outst, offs;
  logic                 start_ok, valid, cmd_hs, res_hs, last_hs;
  logic [KEY_WIDTH-1:0] key;
  logic [1:0]           op;

  assign total = (mode_q == 2'd3) ? {num_q, 1'b0}
                                  : {1'b0, num_q};
  assign outst    = sent - recv;
  assign start_ok = start_i & ((state == IDLE) | (state == DONE));
  assign valid    = (state == RUN) &&
                    (outst < CW'(MAX_OUTSTANDING));
  assign cmd_hs   = valid & cmd_ready_i;
  assign res_hs   = res_valid_i & rdy;
  assign last_hs  = cmd_hs && ((sent + CW'(1)) == total);

  // Galois step, mask 16'hB400
  assign lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400)
                          : (lfsr >> 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (start_i)
          state_n = (num_cmds_i == '0) ? DONE : RUN;
      end
      RUN:   if (last_hs) state_n = DRAIN;
      DRAIN: if (recv == sent) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= '0;
      num_q  <= '0;
      base_q <= '0;
      lfsr   <= LFSR_SEED;
      sent   <= '0;
      recv   <= '0;
      ok     <= '0;
      stall  <= '0;
      err    <= 1'b0;
      rdy    <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (start_ok) begin
        mode_q <= mode_i;
        num_q  <= num_cmds_i;
        base_q <= key_base_i;
        lfsr   <= LFSR_SEED;
        sent   <= '0;
        recv   <= '0;
        ok     <= '0;
        stall  <= '0;
        err    <= 1'b0;
      end else begin
        if (cmd_hs) begin
          sent <= sent + CW'(1);
          lfsr <= lfsr_n;
        end
        // sent is the registered count, so a result racing
        // the first handshake is still unsolicited
        if (res_hs) begin
          if (recv == sent) begin
            err <= 1'b1;
          end else begin
            recv <= recv + CW'(1);
            if (res_ok_i) ok <= ok + CW'(1);
          end
        end
        if (valid && !cmd_ready_i && !(&stall))
          stall <= stall + CW'(1);
      end
    end
  end

  // sent doubles as the command index
  assign offs = ((mode_q == 2'd3) && (sent >= CW'(num_q)))
              ? sent - CW'(num_q) : sent;

  always_comb begin
    key = base_q + KEY_WIDTH'(offs);
    op  = OP_SEARCH;
    unique case (mode_q)
      2'd0: op = OP_INSERT;
      2'd1: op = OP_SEARCH;
      2'd2: begin
        key = base_q + KEY_WIDTH'(lfsr[KEY_SPACE_BITS-1:0]);
        unique case (1'b1)
          lfsr[15:14] == 2'b01: op = OP_INSERT;
          lfsr[15:14] == 2'b10: op = OP_DELETE;
          default:              op = OP_SEARCH;
        endcase
      end
      default: op = (sent >= CW'(num_q)) ? OP_DELETE
                                          : OP_INSERT;
    endcase
  end

  assign cmd_valid_o  = valid;
  assign cmd_key_o    = valid ? key : '0;
  assign cmd_value_o  = valid ? VALUE_WIDTH'(sent) : '0;
  assign cmd_opcode_o = valid ? op : 2'd0;
  assign res_ready_o  = rdy;
  assign busy_o       = (state == RUN) | (state == DRAIN);
  assign done_o       = (state == DONE);
  assign err_o        = err;
  assign sent_cnt_o   = sent;
  assign recv_cnt_o   = recv;
  assign ok_cnt_o     = ok;
  assign stall_cnt_o  = stall;

endmodule

// File: tb/tb_ht_traffic_gen.sv
// tb_ht_traffic_gen: directed vector bench for ht_traffic_gen.
// Expected payload table is hand-computed, incl. LFSR sequence.
module tb_ht_traffic_gen;

  logic        clk = 1'b0;
  logic        rst_i, start_i;
  logic [1:0]  mode_i;
  logic [15:0] num_cmds_i;
  logic [31:0] key_base_i;
  logic        cmd_valid_o, cmd_ready_i;
  logic [31:0] cmd_key_o;
  logic [15:0] cmd_value_o;
  logic [1:0]  cmd_opcode_o;
  logic        res_valid_i, res_ready_o, res_ok_i;
  logic        busy_o, done_o, err_o;
  logic [16:0] sent_cnt_o, recv_cnt_o;
  logic [16:0] ok_cnt_o, stall_cnt_o;

  always #5 clk = ~clk;

  ht_traffic_gen #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .mode_i(mode_i), .num_cmds_i(num_cmds_i),
    .key_base_i(key_base_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_key_o(cmd_key_o), .cmd_value_o(cmd_value_o),
    .cmd_opcode_o(cmd_opcode_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_ok_i(res_ok_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .sent_cnt_o(sent_cnt_o), .recv_cnt_o(recv_cnt_o),
    .ok_cnt_o(ok_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  localparam logic [1:0] SR = 2'd0;
  localparam logic [1:0] IN = 2'd1;
  localparam logic [1:0] DL = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
    logic [15:0] val;
  } exp_t;

  exp_t exp_tab [0:14];
  int   errors = 0;
  int   checks = 0;
  int   cycs;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [1:0] m,
                     input logic [15:0] n,
                     input logic [31:0] base,
                     input int first,
                     input int total,
                     input int sm,
                     output int cc);
    int k, pend, hold, okx, stx, t;
    k = 0; pend = 0; hold = 0;
    okx = 0; stx = 0; cc = 0;
    mode_i = m; num_cmds_i = n;
    key_base_i = base; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    while (k < total && cc < 300) begin
      cmd_ready_i = 1'b1;
      if (sm == 1 && k == 0 && hold < 5)
        cmd_ready_i = 1'b0;
      if (sm == 2)
        cmd_ready_i = 1'($urandom_range(0, 1));
      res_valid_i = (pend > 0);
      res_ok_i = 1'($urandom_range(0, 1));
      if (res_valid_i && res_ok_i) okx++;
      if (cmd_valid_o && !cmd_ready_i) begin
        stx++;
        if (sm == 1 && k == 0) begin
          hold++;
          chk("hold_key", cmd_key_o, exp_tab[first].key);
          chk("hold_op", cmd_opcode_o, exp_tab[first].op);
        end
      end
      if (cmd_valid_o && cmd_ready_i) begin
        chk("key", cmd_key_o, exp_tab[first+k].key);
        chk("op", cmd_opcode_o, exp_tab[first+k].op);
        chk("val", cmd_value_o, exp_tab[first+k].val);
        k++;
        pend++;
      end
      if (res_valid_i) pend--;
      cyc();
      cc++;
    end
    chk("handshakes", k, total);
    cmd_ready_i = 1'b0;
    t = 0;
    while (pend > 0 && t < 50) begin
      res_valid_i = 1'b1;
      res_ok_i = 1'($urandom_range(0, 1));
      if (res_ok_i) okx++;
      pend--;
      cyc();
      t++;
    end
    res_valid_i = 1'b0;
    res_ok_i = 1'b0;
    t = 0;
    while (!done_o && t < 20) begin
      cyc();
      t++;
    end
    chk("done", done_o, 1);
    chk("sent", sent_cnt_o, total);
    chk("recv", recv_cnt_o, total);
    chk("ok_cnt", ok_cnt_o, okx);
    chk("stall_cnt", stall_cnt_o, stx);
  endtask

  initial begin
    exp_tab[0]  = '{IN, 32'h0100_0000, 16'd0};
    exp_tab[1]  = '{IN, 32'h0100_0001, 16'd1};
    exp_tab[2]  = '{IN, 32'h0100_0002, 16'd2};
    exp_tab[3]  = '{IN, 32'h0100_0000, 16'd0};
    exp_tab[4]  = '{IN, 32'h0100_0001, 16'd1};
    exp_tab[5]  = '{DL, 32'h0100_0000, 16'd2};
    exp_tab[6]  = '{DL, 32'h0100_0001, 16'd3};
    // LFSR states ACE1 E270 7138 389C 1C4E 0E27 B313 ED89
    exp_tab[7]  = '{DL, 32'h0000_1001, 16'd0};
    exp_tab[8]  = '{SR, 32'h0000_1000, 16'd1};
    exp_tab[9]  = '{IN, 32'h0000_1008, 16'd2};
    exp_tab[10] = '{SR, 32'h0000_100C, 16'd3};
    exp_tab[11] = '{SR, 32'h0000_100E, 16'd4};
    exp_tab[12] = '{SR, 32'h0000_1007, 16'd5};
    exp_tab[13] = '{DL, 32'h0000_1003, 16'd6};
    exp_tab[14] = '{SR, 32'h0000_1009, 16'd7};

    rst_i = 1'b1; start_i = 1'b0; mode_i = 2'd0;
    num_cmds_i = '0; key_base_i = '0;
    cmd_ready_i = 1'b0; res_valid_i = 1'b0;
    res_ok_i = 1'b0;
    repeat (2) cyc();
    chk("rst_valid", cmd_valid_o, 0);
    chk("rst_rready", res_ready_o, 0);
    chk("rst_sent", sent_cnt_o, 0);
    chk("rst_recv", recv_cnt_o, 0);
    chk("rst_ok", ok_cnt_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    rst_i = 1'b0;
    cyc();
    chk("rready", res_ready_o, 1);

    res_valid_i = 1'b1;
    cyc();
    res_valid_i = 1'b0;
    chk("unsol_err", err_o, 1);
    chk("unsol_recv", recv_cnt_o, 0);

    num_cmds_i = '0; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("zero_done", done_o, 1);
    chk("zero_valid", cmd_valid_o, 0);
    chk("zero_err_clr", err_o, 0);

    run(2'd0, 16'd3, 32'h0100_0000, 0, 3, 0, cycs);
    chk("b2b_cycles", cycs, 3);

    run(2'd3, 16'd2, 32'h0100_0000, 3, 4, 1, cycs);
    chk("hold_stall5", stall_cnt_o, 5);

    run(2'd2, 16'd8, 32'h0000_1000, 7, 8, 0, cycs);
    run(2'd2, 16'd8, 32'h0000_1000, 7, 8, 2, cycs);

    mode_i = 2'd1; num_cmds_i = 16'd4;
    key_base_i = 32'h20; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    cmd_ready_i = 1'b1;
    chk("mo_v0", cmd_valid_o, 1);
    cyc();
    chk("mo_v1", cmd_valid_o, 1);
    cyc();
    chk("mo_block", cmd_valid_o, 0);
    cyc();
    chk("mo_block2", cmd_valid_o, 0);
    chk("mo_sent2", sent_cnt_o, 2);
    res_valid_i = 1'b1;
    cyc();
    res_valid_i = 1'b0;
    chk("mo_reassert", cmd_valid_o, 1);
    chk("mo_key", cmd_key_o, 32'h22);
    chk("mo_op", cmd_opcode_o, SR);
    cyc();
    chk("mo_block3", cmd_valid_o, 0);
    res_valid_i = 1'b1;
    cyc();
    res_valid_i = 1'b0;
    chk("mo_v3", cmd_valid_o, 1);
    cyc();
    cmd_ready_i = 1'b0;
    chk("mo_sent4", sent_cnt_o, 4);
    chk("mo_drain_busy", busy_o, 1);
    chk("mo_drain_nd", done_o, 0);
    cyc();
    chk("mo_drain_hold", busy_o, 1);
    res_valid_i = 1'b1;
    cyc();
    cyc();
    res_valid_i = 1'b0;
    cyc();
    chk("mo_done", done_o, 1);
    chk("mo_recv", recv_cnt_o, 4);

    mode_i = 2'd0; num_cmds_i = 16'd5;
    key_base_i = '0; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    cyc();
    cyc();
    chk("mr_held", cmd_valid_o, 1);
    rst_i = 1'b1;
    cyc();
    chk("mr_valid", cmd_valid_o, 0);
    chk("mr_sent", sent_cnt_o, 0);
    chk("mr_stall", stall_cnt_o, 0);
    chk("mr_busy", busy_o, 0);
    rst_i = 1'b0;
    cyc();
    run(2'd0, 16'd3, 32'h0100_0000, 0, 3, 0, cycs);
    chk("mr_rerun_cyc", cycs, 3);
    chk("mr_err", err_o, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/ht_traffic_gen.md
Name: ht_traffic_gen

Overview:
- Parametrised, synthesizable command/traffic generator for hash_table_top. It drives the command interface with a full valid/ready handshake and sinks the result interface.
- Generates sequential or LFSR-pseudo-random SEARCH/INSERT/DELETE streams with a bounded number of outstanding commands.
- Counts issued commands, returned results, successful results and stall cycles, for on-chip self-test and for use as a bench stimulus engine.

Parameters:
- KEY_WIDTH, 32, key width; matches the hash_table package.
- VALUE_WIDTH, 16, value width; matches the hash_table package.
- CNT_WIDTH, 16, width of num_cmds_i. Status counters are CNT_WIDTH+1 bits.
- KEY_SPACE_BITS, 4, number of LFSR bits added to key_base_i in random mode; a small value forces collisions.
- MAX_OUTSTANDING, 4, maximum number of commands issued but not yet answered (sent - recv); range 1..255.
- LFSR_SEED, 16'hACE1, LFSR load value on start; must be nonzero.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  pulse; starts a run when the FSM is in IDLE or DONE
- mode_i  in  2  0 = sequential INSERT, 1 = sequential SEARCH, 2 = random mix, 3 = INSERT then DELETE
- num_cmds_i  in  CNT_WIDTH  number of commands (mode 3: keys per phase); sampled on start
- key_base_i  in  KEY_WIDTH  base key; sampled on start
- cmd_valid_o  out  1  command valid
- cmd_ready_i  in  1  command ready from DUT
- cmd_key_o  out  KEY_WIDTH  command key
- cmd_value_o  out  VALUE_WIDTH  command value
- cmd_opcode_o  out  2  ht_opcode_t encoding (OP_SEARCH, OP_INSERT, OP_DELETE)
- res_valid_i  in  1  result valid
- res_ready_o  out  1  result ready
- res_ok_i  in  1  result success flag (found / inserted / deleted)
- busy_o  out  1  FSM is in RUN or DRAIN
- done_o  out  1  FSM is in DONE
- err_o  out  1  sticky error: result received with no command outstanding
- sent_cnt_o  out  CNT_WIDTH+1  commands accepted by DUT
- recv_cnt_o  out  CNT_WIDTH+1  results accepted
- ok_cnt_o  out  CNT_WIDTH+1  results with res_ok_i = 1
- stall_cnt_o  out  CNT_WIDTH+1  cycles with cmd_valid_o = 1 and cmd_ready_i = 0; saturates at all-ones

Behaviour:
- Reset:
  - FSM enters IDLE.
  - All outputs are 0, including res_ready_o, all counters and err_o.
  - LFSR loads LFSR_SEED.
  - Reset in any state aborts the run at the next edge; cmd_valid_o drops even while a command is held.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start_i:
    - latch mode, num_cmds and key_base;
    - clear counters, err_o and the index; reseed the LFSR;
    - go to RUN, or straight to DONE if num_cmds = 0.
  - start_i is ignored in RUN and DRAIN.
  - RUN -> DRAIN on the cycle the last command handshakes (sent reaches total).
  - DRAIN -> DONE when recv = sent.
  - DONE holds until the next start_i or reset.
- Total command count: num_cmds, or 2*num_cmds in mode 3.
- Issue rule:
  - In RUN, cmd_valid_o is asserted when (sent - recv) < MAX_OUTSTANDING.
  - Once asserted, valid and payload stay stable until cmd_ready_i = 1; never retract.
  - Handshake = valid & ready. On a handshake, the next command may be presented in the following cycle, giving back-to-back throughput of 1 per cycle.
- Payload for index i (0-based, per handshake):
  - Mode 0: key = key_base + i, opcode INSERT.
  - Mode 1: key = key_base + i, opcode SEARCH.
  - Mode 2:
    - key = key_base + zero-extended lfsr[KEY_SPACE_BITS-1:0];
    - opcode from lfsr[15:14]: 00 SEARCH, 01 INSERT, 10 DELETE, 11 SEARCH.
  - Mode 3: i < N gives key_base + i, INSERT; i >= N gives key_base + (i - N), DELETE.
  - Value = i[VALUE_WIDTH-1:0] in all modes.
  - Key addition wraps modulo 2^KEY_WIDTH.
- LFSR:
  - 16-bit Galois, taps for x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances only on a command handshake, so payload depends only on handshake order and not on stalls.
- Results:
  - res_ready_o = 1 in every state after reset.
  - A result handshake increments recv; ok_cnt also increments if res_ok_i = 1.
  - If a result arrives when recv = sent, including the same cycle as a command handshake that has not yet been counted, err_o is set and the result is not counted.
  - Outstanding is computed from registered counters; a same-cycle command handshake and result handshake both apply.
- Counters never wrap except stall_cnt, which saturates instead.

Test Plan:
- Mode 0, N = 3, key_base 32'h0100_0000, ready always 1 -> keys 0100_0000/01/02, values 0/1/2, opcode INSERT, cycles back-to-back; one result per command -> sent = recv = 3, done_o = 1.
- Mode 3, N = 2, key_base 32'h0100_0000, ready held 0 for 5 cycles at first valid -> payload stable during hold, stall_cnt = 5; order INSERT 00, INSERT 01, DELETE 00, DELETE 01; sent = 4.
- MAX_OUTSTANDING = 2, results withheld -> valid drops after 2 handshakes; releasing one result -> valid reasserts the next cycle; FSM stays in DRAIN until recv = sent.
- Mode 2, N = 8, seed 16'hACE1 -> opcode/key sequence matches the reference-model LFSR; inserting random stalls gives an identical sequence.
- Unsolicited res_valid_i in IDLE -> err_o = 1, recv = 0; num_cmds = 0 with start_i -> DONE next cycle with no valid.
- rst_i mid-RUN while valid is held -> valid = 0 and counters = 0 next cycle; a subsequent start_i runs cleanly.
